mem_sync_fifo_ctrl: RTL and testbench

- Controller that turns an external single-port synchronous RAM into a FIFO with valid/ready streams.
- Sits directly upstream of the 256x16 memory stage and drives its address / write-data / write-enable.
- Consumes that memory's registered read data, which has one-cycle read latency.
- Shares the single RAM port between pushes and prefetch reads, and buffers reads in a 2-entry output stage for full read throughput.

---
 rtl/mem_sync_fifo_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_sync_fifo_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sync_fifo_ctrl.sv
// FIFO controller over a single-port synchronous RAM.
// Shares the RAM port between pushes and prefetch reads.
module mem_sync_fifo_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [ADDR_W+1:0] count,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam logic [ADDR_W:0] MEM_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   mem_cnt_q, mem_cnt_d;
    logic [1:0]        ob_cnt_q, ob_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] ob0_q, ob0_d;
    logic [DATA_W-1:0] ob1_q, ob1_d;

    logic       pop;
    logic       has_mem;
    logic       can_wr;
    logic       rd_ok;
    logic       urgent;
    logic       rd_grant;
    logic       wr_grant;
    logic [2:0] occ;

    // Port arbitration: a read wins only when the output stage would starve.
    always_comb begin
        pop      = out_valid && out_ready;
        occ      = {1'b0, ob_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
        has_mem  = mem_cnt_q != '0;
        can_wr   = mem_cnt_q != MEM_FULL;
        rd_ok    = has_mem && (occ <= 3'd1);
        urgent   = rd_ok && (occ == 3'd0);
        rd_grant = urgent || (rd_ok && !(in_valid && can_wr));
        in_ready = rst_n && can_wr && !urgent;
        wr_grant = in_valid && in_ready;
    end

    // Next-state for pointers, RAM occupancy and the two-entry output stage.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_cnt_d = mem_cnt_q;
        ob_cnt_d  = ob_cnt_q;
        ob0_d     = ob0_q;
        ob1_d     = ob1_q;
        rd_pend_d = rd_grant;
        if (wr_grant) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            mem_cnt_d = mem_cnt_q + 1'b1;
        end
        if (rd_grant) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            mem_cnt_d = mem_cnt_q - 1'b1;
        end
        unique case (1'b1)
            (pop && rd_pend_q): begin
                if (ob_cnt_q == 2'd2) begin
                    ob0_d = ob1_q;
                    ob1_d = mem_rd;
                end else begin
                    ob0_d = mem_rd;
                end
            end
            (pop && !rd_pend_q): begin
                ob0_d    = ob1_q;
                ob_cnt_d = ob_cnt_q - 2'd1;
            end
            (!pop && rd_pend_q): begin
                if (ob_cnt_q == 2'd0) begin
                    ob0_d = mem_rd;
                end else begin
                    ob1_d = mem_rd;
                end
                ob_cnt_d = ob_cnt_q + 2'd1;
            end
            default: begin
            end
        endcase
    end

    // State registers; reset discards any in-flight read and held data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            ob_cnt_q  <= '0;
            rd_pend_q <= 1'b0;
            ob0_q     <= '0;
            ob1_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            ob_cnt_q  <= ob_cnt_d;
            rd_pend_q <= rd_pend_d;
            ob0_q     <= ob0_d;
            ob1_q     <= ob1_d;
        end
    end

    // Stream outputs, occupancy and RAM drive.
    always_comb begin
        out_valid   = ob_cnt_q != 2'd0;
        out_data    = ob0_q;
        count       = {1'b0, mem_cnt_q}
                    + {{(ADDR_W+1){1'b0}}, rd_pend_q}
                    + {{ADDR_W{1'b0}}, ob_cnt_q};
        mem_wen     = wr_grant;
        mem_address = wr_grant ? wr_ptr_q : rd_ptr_q;
        mem_wd      = in_data;
    end

endmodule

// File: tb/tb_mem_sync_fifo_ctrl.sv
// Bench for mem_sync_fifo_ctrl with a behavioural RAM.
// Scoreboard queue of accepted pushes, separate pop monitor.
module tb_mem_sync_fifo_ctrl;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [AW+1:0] count;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wd;
    logic          mem_wen;
    logic [DW-1:0] mem_rd;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];

    int n_chk = 0;
    int n_pass = 0;
    int n_acc = 0;
    int n_pop = 0;

    mem_sync_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .count(count),
        .mem_address(mem_address),
        .mem_wd(mem_wd),
        .mem_wen(mem_wen),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) ram[mem_address] <= mem_wd;
        mem_rd <= ram[mem_address];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
                      nm, act, want, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push recorder: every accepted word enters the scoreboard.
    initial begin : recorder
        logic [AW-1:0] wp;
        wp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                wp = '0;
                chk("rst_wen", mem_wen, 0);
                chk("rst_in_ready", in_ready, 0);
            end else if (in_valid && in_ready) begin
                chk("wr_wen", mem_wen, 1);
                chk("wr_addr", mem_address, wp);
                chk("wr_data", mem_wd, in_data);
                exp_q.push_back(in_data);
                wp++;
                n_acc++;
            end else begin
                chk("idle_wen", mem_wen, 0);
            end
        end
    end

    // Output monitor: pops compare against the scoreboard head.
    initial begin : monitor
        int mcnt;
        logic hold_v;
        logic [DW-1:0] hold_d;
        logic [DW-1:0] want;
        mcnt = 0;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mcnt = 0;
                hold_v = 1'b0;
                chk("rst_out_valid", out_valid, 0);
                chk("rst_count", count, 0);
            end else begin
                chk("count", count, mcnt);
                if (hold_v) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, hold_d);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL pop_extra: got 0x%0h want none",
                                 out_data);
                    end else begin
                        want = exp_q.pop_front();
                        chk("pop_data", out_data, want);
                    end
                    n_pop++;
                end
                mcnt += int'(in_valid && in_ready)
                      - int'(out_valid && out_ready);
                hold_v = out_valid && !out_ready;
                hold_d = out_data;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        chk("rel_count", count, 0);
        step();
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = (count == 0);
            if (!done) step();
        end
        chk("drained", done, 1);
        step();
    endtask

    task automatic push_n(input int n, input int budget);
        int n0;
        bit acc;
        n0 = n_acc;
        in_valid = 1'b1;
        for (int i = 0; i < budget && (n_acc - n0) < n; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (acc) in_data = in_data + 1'b1;
        end
        chk("push_n", n_acc - n0, n);
    endtask

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = DW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n0;
        int np0;
        int po0;
        bit acc;
        bit seen;

        do_reset();

        // single word latency through an empty FIFO
        in_valid = 1'b1;
        in_data = 16'h1234;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t2_c0_wen", mem_wen, 1);
        chk("t2_c0_addr", mem_address, 0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_c1_wen", mem_wen, 0);
        chk("t2_c1_addr", mem_address, 0);
        step();
        @(negedge clk);
        chk("t2_c2_valid", out_valid, 0);
        step();
        @(negedge clk);
        chk("t2_c3_valid", out_valid, 1);
        chk("t2_c3_data", out_data, 16'h1234);
        step();
        @(negedge clk);
        chk("t2_c4_count", count, 0);
        step();

        // fill to capacity, then drain at full rate
        do_reset();
        n0 = n_acc;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (acc) in_data = in_data + 1'b1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_accepted", n_acc - n0, 258);
        chk("t3_count", count, 258);
        chk("t3_in_ready", in_ready, 0);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 258; i++) begin
            @(negedge clk);
            chk("t3_drain_valid", out_valid, 1);
            step();
        end
        @(negedge clk);
        chk("t3_empty_count", count, 0);
        chk("t3_empty_valid", out_valid, 0);
        step();

        // urgent read steals the port from a push
        do_reset();
        out_ready = 1'b0;
        push_n(4, 20);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_count", count, 4);
        chk("t5_in_ready", in_ready, 0);
        chk("t5_wen", mem_wen, 0);
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("t5_next_in_ready", in_ready, 1);
        chk("t5_next_wen", mem_wen, 1);
        step();
        drain(40);

        // simultaneous push and pop pressure with 10 preloaded
        do_reset();
        out_ready = 1'b0;
        push_n(10, 40);
        np0 = n_acc;
        po0 = n_pop;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (acc) in_data = in_data + 1'b1;
        end
        chk("t4_pushes", (n_acc - np0) >= 30, 1);
        chk("t4_pops", (n_pop - po0) >= 30, 1);
        drain(300);

        // reset while a read is in flight
        do_reset();
        in_valid = 1'b1;
        in_data = 16'h5555;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rel_in_ready", in_ready, 1);
        step();
        in_valid = 1'b1;
        in_data = 16'hBEEF;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
            if (!seen) step();
        end
        chk("t6_valid", seen, 1);
        chk("t6_data", out_data, 16'hBEEF);
        step();
        drain(20);

        // random traffic, a mid-stream reset, more random traffic
        random_run(400);
        do_reset();
        random_run(2000);
        drain(400);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
